// File: rtl/avalon_bridge_pkg.sv
// Shared constants and helpers for the same-clock Avalon-MM pipeline bridge.
package avalon_bridge_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 6;
  localparam int DEF_CMD_DEPTH = 4;
  localparam int DEF_RSP_DEPTH = 8;

  // Command word layout, LSB first: write data, wr flag, rd flag, byte enables, word address.
  // Offsets below are relative to the first bit above the write-data field.
  localparam int CMD_WR_OFS = 0;
  localparam int CMD_RD_OFS = 1;
  localparam int CMD_BE_OFS = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int cmd_width(input int data_w, input int addr_w, input int be_w);
    return data_w + addr_w + be_w + 2;
  endfunction

endpackage

// File: rtl/bridge_sync_fifo.sv
// Show-ahead single-clock FIFO: head word visible whenever non-empty, pop takes effect at the edge.
// Push on a full FIFO is accepted only together with a pop.
module bridge_sync_fifo
  import avalon_bridge_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       out_data,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign out_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= in_data;
  end

  // Depth is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/avalon_mm_pipeline_bridge.sv
// Same-clock Avalon-MM bridge: command FIFO toward the master side, read-credit limited issue,
// response FIFO drained every cycle into a registered slave-side read-data port.
module avalon_mm_pipeline_bridge
  import avalon_bridge_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int CMD_DEPTH = DEF_CMD_DEPTH,
  parameter int RSP_DEPTH = DEF_RSP_DEPTH
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [ADDR_W-1:0]                   slave_address,
  input  logic [DATA_W/8-1:0]                 slave_byteenable,
  input  logic                                slave_read,
  input  logic                                slave_write,
  input  logic [DATA_W-1:0]                   slave_writedata,
  output logic                                slave_waitrequest,
  output logic [DATA_W-1:0]                   slave_readdata,
  output logic                                slave_readdatavalid,
  output logic                                slave_endofpacket,
  output logic [ADDR_W+clog2(DATA_W/8)-1:0]   master_address,
  output logic [DATA_W/8-1:0]                 master_byteenable,
  output logic                                master_read,
  output logic                                master_write,
  output logic [DATA_W-1:0]                   master_writedata,
  input  logic                                master_waitrequest,
  input  logic [DATA_W-1:0]                   master_readdata,
  input  logic                                master_readdatavalid,
  input  logic                                master_endofpacket,
  output logic [clog2(RSP_DEPTH):0]           pending_reads,
  output logic                                err_unexpected_rsp
);

  localparam int BE_W     = DATA_W / 8;
  localparam int BA_W     = clog2(BE_W);
  localparam int MA_W     = ADDR_W + BA_W;
  localparam int CW       = clog2(RSP_DEPTH);
  localparam int CMD_W    = cmd_width(DATA_W, ADDR_W, BE_W);
  localparam int RSP_W    = DATA_W + 1;
  localparam int WR_BIT   = DATA_W + CMD_WR_OFS;
  localparam int RD_BIT   = DATA_W + CMD_RD_OFS;
  localparam int BE_LSB   = DATA_W + CMD_BE_OFS;
  localparam int ADDR_LSB = BE_LSB + BE_W;
  localparam logic [CW+1:0] RSP_LIM = (CW+2)'(RSP_DEPTH);

  logic [CMD_W-1:0]            cmd_in;
  logic [CMD_W-1:0]            cmd_head;
  logic                        cmd_push;
  logic                        cmd_pop;
  logic                        cmd_full;
  logic                        cmd_empty;
  logic [clog2(CMD_DEPTH):0]   cmd_count;

  logic [RSP_W-1:0]            rsp_head;
  logic                        rsp_push;
  logic                        rsp_full;
  logic                        rsp_empty;
  logic [CW:0]                 rsp_count;

  logic                        head_rd;
  logic                        head_wr;
  logic [ADDR_W-1:0]           head_addr;
  logic [CW+1:0]               credit_sum;
  logic                        credit_ok;
  logic                        rd_issue;
  logic                        unused_cmd_count;

  // Command capture; a simultaneous read+write is kept as the write alone.
  assign slave_waitrequest = reset | cmd_full;
  assign cmd_push = (slave_read | slave_write) & ~slave_waitrequest;
  assign cmd_in   = {slave_address, slave_byteenable, slave_read & ~slave_write,
                     slave_write, slave_writedata};

  bridge_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (cmd_push),
    .in_data  (cmd_in),
    .pop      (cmd_pop),
    .out_data (cmd_head),
    .full     (cmd_full),
    .empty    (cmd_empty),
    .count    (cmd_count)
  );

  assign unused_cmd_count = &{1'b0, cmd_count};

  assign head_rd   = cmd_head[RD_BIT];
  assign head_wr   = cmd_head[WR_BIT];
  assign head_addr = cmd_head[ADDR_LSB +: ADDR_W];

  // Every outstanding read owns one response slot, either in flight or already buffered.
  // The sum only grows on a read issue, so a granted read keeps its credit while stalled.
  assign credit_sum = {1'b0, pending_reads} + {1'b0, rsp_count};
  assign credit_ok  = ~rsp_full & (credit_sum < RSP_LIM);

  assign master_read       = ~cmd_empty & head_rd & credit_ok;
  assign master_write      = ~cmd_empty & head_wr;
  assign master_address    = MA_W'(head_addr) << BA_W;
  assign master_byteenable = cmd_head[BE_LSB +: BE_W];
  assign master_writedata  = cmd_head[DATA_W-1:0];
  assign cmd_pop           = (master_read | master_write) & ~master_waitrequest;
  assign rd_issue          = master_read & ~master_waitrequest;

  assign rsp_push = master_readdatavalid & (pending_reads != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_reads <= '0;
    end else begin
      case ({rd_issue, rsp_push})
        2'b10:   pending_reads <= pending_reads + (CW+1)'(1);
        2'b01:   pending_reads <= pending_reads - (CW+1)'(1);
        default: pending_reads <= pending_reads;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_unexpected_rsp <= 1'b0;
    end else if (master_readdatavalid && pending_reads == '0) begin
      err_unexpected_rsp <= 1'b1;
    end
  end

  bridge_sync_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (rsp_push),
    .in_data  ({master_readdata, master_endofpacket}),
    .pop      (~rsp_empty),
    .out_data (rsp_head),
    .full     (rsp_full),
    .empty    (rsp_empty),
    .count    (rsp_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slave_readdatavalid <= 1'b0;
      slave_readdata      <= '0;
      slave_endofpacket   <= 1'b0;
    end else begin
      slave_readdatavalid <= ~rsp_empty;
      if (!rsp_empty) begin
        slave_readdata    <= rsp_head[RSP_W-1:1];
        slave_endofpacket <= rsp_head[0];
      end
    end
  end

endmodule
